datapath_sequencer: RTL
=======================

Name: datapath_sequencer

Overview:
Command-level controller for the register-file/ALU datapath. It accepts one command at a time over a valid/ready interface and drives the datapath control signals Wen, WA, RAA, RAB, Op and Sel. It sequences operand read, execution, write-back and optional repetition, then returns a status response that carries the EQ flag. It sits between the host command source and the datapath. It is the only agent that may assert Wen.

Parameters:
EXEC_LAT, 1, cycles from operand/Op presentation to a valid result or Flag (range 1..7)
REP_W, 4, width of the repeat count (max repeats = 2**REP_W-1)

Ports:
clk  in  1  system clock
rst_n  in  1  reset, asynchronous, active low
cmd_valid  in  1  command offered
cmd_ready  out  1  sequencer can accept; high only in IDLE
cmd_kind  in  2  0=ALU, 1=LOAD, 2=NOP, 3=reserved
cmd_op  in  3  ALU op: 000 ADD, 001 SHR, 010 EQ, 011 AND, 100 MOV, 101-111 illegal
cmd_wa  in  4  destination register
cmd_raa  in  4  source A register
cmd_rab  in  4  source B register
cmd_sel  in  4  InPort nibble index for LOAD
cmd_rep  in  REP_W  extra iterations (0 = execute once)
rsp_valid  out  1  response available
rsp_ready  in  1  response consumed
rsp_flag  out  1  Flag captured by EQ; 0 otherwise
rsp_err  out  1  illegal command
Wen  out  1  register write enable
WA  out  4  write address
RAA  out  4  read address A
RAB  out  4  read address B
Op  out  3  ALU operation
Sel  out  4  InPort nibble select
Flag  in  1  datapath EQ result
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (asynchronous, rst_n low): state IDLE; Wen=0; WA/RAA/RAB/Sel=0; Op=3'b100 (MOV, harmless); rsp_valid=0; rsp_flag=0; rsp_err=0; busy=0; cmd_ready=1 after reset release. Reset mid-command aborts the command and produces no response.
- States: IDLE, OPER, WRITE, RESP.
- IDLE: cmd_ready=1. When cmd_valid is high, latch all cmd_* fields.
  - ALU legal -> OPER.
  - LOAD -> OPER with Op=MOV and Sel=cmd_sel.
  - NOP, reserved kind or illegal op -> RESP. rsp_err=1 for reserved kind or illegal op; NOP gives rsp_err=0. Wen is never asserted in these cases.
- OPER: drive RAA, RAB, Op and Sel from the latched fields; Wen=0. Stay exactly EXEC_LAT cycles, counted by an internal counter. On the last cycle:
  - EQ: sample Flag into rsp_flag, then -> RESP. No write-back.
  - All other ops -> WRITE.
- WRITE: Wen=1 for exactly one cycle with WA=latched wa; RAA/RAB/Op held stable.
  - If the repeat counter is nonzero: decrement it, set RAA=latched wa (the next iteration operates on the result, e.g. repeated SHR), -> OPER.
  - Otherwise -> RESP.
- RESP: rsp_valid=1; rsp_flag and rsp_err held stable until rsp_ready. On the handshake cycle -> IDLE and rsp_valid deasserts next cycle. If rsp_ready is already high on entry, the response lasts one cycle.
- Control outputs change only on state transitions; they are stable whenever Wen=0 within one command.
- Latency (rsp_ready tied high): accept -> first Wen = EXEC_LAT+1 cycles. Each repeat adds EXEC_LAT+1 cycles. EQ: rsp_valid EXEC_LAT+1 cycles after accept.
- Back-to-back commands: no new command accepted until the response handshake completes. cmd_ready may go high the cycle after the rsp handshake.
- cmd_rep is ignored for EQ, NOP and illegal commands. For LOAD, a repeat rewrites the same value.
- Exactly one Wen pulse per iteration. Never more than cmd_rep+1 pulses per command.

Decomposition:
- Package datapath_pkg: alu_op_e (ADD, SHR, EQ, AND, MOV), cmd_kind_e, seq_state_e, and constant OP_IDLE = MOV.
- One natural sub-module, seq_counter: a loadable down-counter used for both the EXEC_LAT wait and the repeat count. It is instanced twice.

Test Plan:
- Reset mid-OPER (rst_n low during ALU ADD) -> Wen=0, busy=0, rsp_valid=0 immediately; cmd_ready=1 after release.
- ALU ADD wa=3 raa=1 rab=2 rep=0, EXEC_LAT=1 -> one Wen pulse at cycle 2 after accept with WA=3, Op=000; then rsp_valid with rsp_err=0, rsp_flag=0.
- ALU SHR wa=5 raa=5 rep=3 -> exactly 4 Wen pulses at WA=5, spaced EXEC_LAT+1 cycles; RAA=5 throughout; one response.
- ALU EQ raa=4 rab=4 with Flag=1 driven on the last OPER cycle -> no Wen; rsp_flag=1. Repeat with Flag=0 -> rsp_flag=0.
- Illegal op 3'b110, and separately cmd_kind=3 -> no Wen; rsp_err=1; next command still accepted.
- LOAD sel=9 wa=7 with rsp_ready held low for 5 cycles -> Sel=9, Op=100, one Wen at WA=7; rsp_valid held 5 cycles with stable fields; cmd_ready=0 until the handshake.

Source files
------------

// File: rtl/datapath_pkg.sv
// Shared types and constants for the register-file/ALU command sequencer.
package datapath_pkg;

  localparam int unsigned REG_AW = 4;
  localparam int unsigned OP_W   = 3;
  localparam int unsigned SEL_W  = 4;
  localparam int unsigned LAT_W  = 3;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SHR = 3'd1,
    OP_EQ  = 3'd2,
    OP_AND = 3'd3,
    OP_MOV = 3'd4
  } alu_op_e;

  typedef enum logic [1:0] {
    KIND_ALU  = 2'd0,
    KIND_LOAD = 2'd1,
    KIND_NOP  = 2'd2,
    KIND_RSVD = 2'd3
  } cmd_kind_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_OPER  = 2'd1,
    S_WRITE = 2'd2,
    S_RESP  = 2'd3
  } seq_state_e;

  // MOV is the harmless op parked on the datapath when nothing is running.
  localparam alu_op_e OP_IDLE = OP_MOV;

  function automatic logic op_legal(input logic [OP_W-1:0] op);
    return op <= OP_W'(OP_MOV);
  endfunction

endpackage

// File: rtl/datapath_sequencer_if.sv
// Command and response handshake bundle between host and sequencer.
interface datapath_sequencer_if #(
  parameter int unsigned REP_W = 4
);
  import datapath_pkg::*;

  logic              cmd_valid;
  logic              cmd_ready;
  logic [1:0]        cmd_kind;
  logic [OP_W-1:0]   cmd_op;
  logic [REG_AW-1:0] cmd_wa;
  logic [REG_AW-1:0] cmd_raa;
  logic [REG_AW-1:0] cmd_rab;
  logic [SEL_W-1:0]  cmd_sel;
  logic [REP_W-1:0]  cmd_rep;
  logic              rsp_valid;
  logic              rsp_ready;
  logic              rsp_flag;
  logic              rsp_err;

  modport master (
    output cmd_valid, cmd_kind, cmd_op, cmd_wa, cmd_raa, cmd_rab, cmd_sel, cmd_rep,
    input  cmd_ready,
    input  rsp_valid, rsp_flag, rsp_err,
    output rsp_ready
  );

  modport slave (
    input  cmd_valid, cmd_kind, cmd_op, cmd_wa, cmd_raa, cmd_rab, cmd_sel, cmd_rep,
    output cmd_ready,
    output rsp_valid, rsp_flag, rsp_err,
    input  rsp_ready
  );

endinterface

// File: rtl/datapath_sequencer_seq_counter.sv
// Loadable saturating down-counter; zero_c flags the final count.
module seq_counter #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero_c
);

  logic [W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - W'(1);
    end
  end

  assign zero_c = (count == '0);

endmodule

// File: rtl/datapath_sequencer.sv
// Command-level controller: sequences operand read, execute, write-back and
// repeats on the register-file/ALU datapath, then returns a status response.
module datapath_sequencer
  import datapath_pkg::*;
#(
  parameter int unsigned EXEC_LAT = 1,
  parameter int unsigned REP_W    = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  datapath_sequencer_if.slave bus,
  output logic               Wen,
  output logic [REG_AW-1:0]  WA,
  output logic [REG_AW-1:0]  RAA,
  output logic [REG_AW-1:0]  RAB,
  output logic [OP_W-1:0]    Op,
  output logic [SEL_W-1:0]   Sel,
  input  logic               Flag,
  output logic               busy
);

  seq_state_e        state, state_d;
  logic              wen_d;
  logic [REG_AW-1:0] wa_d, raa_d, rab_d;
  logic [OP_W-1:0]   op_d;
  logic [SEL_W-1:0]  sel_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_flag_q, rsp_flag_d;
  logic              rsp_err_q, rsp_err_d;
  logic              cmd_ready_q;
  logic              lat_load, lat_dec, lat_zero_c;
  logic              rep_load, rep_dec, rep_zero_c;

  // Execution-latency wait, reloaded at the start of every iteration.
  seq_counter #(.W(LAT_W)) u_lat_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (lat_load),
    .load_val (LAT_W'(EXEC_LAT - 1)),
    .dec      (lat_dec),
    .zero_c   (lat_zero_c)
  );

  // Remaining extra iterations for the current command.
  seq_counter #(.W(REP_W)) u_rep_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (rep_load),
    .load_val (bus.cmd_rep),
    .dec      (rep_dec),
    .zero_c   (rep_zero_c)
  );

  assign lat_dec = (state == S_OPER);

  always_comb begin
    state_d     = state;
    wen_d       = 1'b0;
    wa_d        = WA;
    raa_d       = RAA;
    rab_d       = RAB;
    op_d        = Op;
    sel_d       = Sel;
    rsp_valid_d = rsp_valid_q;
    rsp_flag_d  = rsp_flag_q;
    rsp_err_d   = rsp_err_q;
    lat_load    = 1'b0;
    rep_load    = 1'b0;
    rep_dec     = 1'b0;

    case (state)
      S_IDLE: begin
        if (bus.cmd_valid) begin
          rep_load   = 1'b1;
          rsp_flag_d = 1'b0;
          rsp_err_d  = 1'b0;
          case (bus.cmd_kind)
            KIND_ALU: begin
              if (op_legal(bus.cmd_op)) begin
                state_d = S_OPER;
                op_d    = bus.cmd_op;
              end else begin
                state_d   = S_RESP;
                rsp_err_d = 1'b1;
              end
            end
            KIND_LOAD: begin
              state_d = S_OPER;
              op_d    = OP_W'(OP_MOV);
            end
            KIND_NOP: state_d = S_RESP;
            default: begin
              state_d   = S_RESP;
              rsp_err_d = 1'b1;
            end
          endcase
          // Datapath controls only move for commands that actually execute.
          if (state_d == S_OPER) begin
            lat_load = 1'b1;
            wa_d     = bus.cmd_wa;
            raa_d    = bus.cmd_raa;
            rab_d    = bus.cmd_rab;
            sel_d    = bus.cmd_sel;
          end else begin
            rsp_valid_d = 1'b1;
          end
        end
      end

      S_OPER: begin
        if (lat_zero_c) begin
          if (Op == OP_W'(OP_EQ)) begin
            state_d     = S_RESP;
            rsp_valid_d = 1'b1;
            rsp_flag_d  = Flag;
          end else begin
            state_d = S_WRITE;
            wen_d   = 1'b1;
          end
        end
      end

      S_WRITE: begin
        if (!rep_zero_c) begin
          // Next iteration consumes the value just written.
          state_d  = S_OPER;
          rep_dec  = 1'b1;
          lat_load = 1'b1;
          raa_d    = WA;
        end else begin
          state_d     = S_RESP;
          rsp_valid_d = 1'b1;
        end
      end

      S_RESP: begin
        if (bus.rsp_ready) begin
          state_d     = S_IDLE;
          rsp_valid_d = 1'b0;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      Wen         <= 1'b0;
      WA          <= '0;
      RAA         <= '0;
      RAB         <= '0;
      Op          <= OP_W'(OP_IDLE);
      Sel         <= '0;
      rsp_valid_q <= 1'b0;
      rsp_flag_q  <= 1'b0;
      rsp_err_q   <= 1'b0;
      busy        <= 1'b0;
      cmd_ready_q <= 1'b1;
    end else begin
      state       <= state_d;
      Wen         <= wen_d;
      WA          <= wa_d;
      RAA         <= raa_d;
      RAB         <= rab_d;
      Op          <= op_d;
      Sel         <= sel_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_flag_q  <= rsp_flag_d;
      rsp_err_q   <= rsp_err_d;
      busy        <= (state_d != S_IDLE);
      cmd_ready_q <= (state_d == S_IDLE);
    end
  end

  assign bus.cmd_ready = cmd_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_flag  = rsp_flag_q;
  assign bus.rsp_err   = rsp_err_q;

endmodule
